uart_tx_state_machine: RTL and testbench
========================================

UART_TX_STATE_MACHINE -- requirements
Module: uart_tx_state_machine

Interface
REQ-001 SHALL have parameter baudrate, default 187_500, line bit rate in bits/s.
REQ-002 SHALL have parameter clk_freq_MHz, default 80, clk frequency in MHz.
REQ-003 SHALL have parameter de_hold_bits, default 1, bit periods DE stays asserted after the last stop bit.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port data, input, 8, byte to transmit.
REQ-007 SHALL have port data_valid, input, 1, data is offered.
REQ-008 SHALL have port ready, output, 1, holding register is empty and a byte can be accepted.
REQ-009 SHALL have port tx, output, 1, serial line; idle high.
REQ-010 SHALL have port de, output, 1, RS-485 driver enable.
REQ-011 SHALL have port busy, output, 1, a frame is in progress, DE hold is active, or the holding register is full.
REQ-012 SHALL have port tx_done, output, 1, one-cycle pulse when a stop bit completes.

Function
REQ-013 SHALL use clk_per_baud = (clk_freq_MHz*1_000_000)/baudrate, truncated; every bit SHALL last exactly clk_per_baud cycles, with a 16-bit counter (426 at defaults).
REQ-014 SHALL use frame format 8N1: one start bit (0), eight data bits LSB first, one stop bit (1); 10*clk_per_baud cycles per frame.
REQ-015 SHALL accept a byte on a rising edge with data_valid && ready, storing it in a one-byte holding register.
REQ-016 SHALL define ready as the negation of the holding-full flag; ready SHALL be high after reset.
REQ-017 SHALL use states IDLE, START_BIT, DATA (bit index 0..7), STOP_BIT, DE_HOLD.
REQ-018 SHALL, in IDLE or DE_HOLD with holding full, move the byte to the shifter on the next edge, clear holding, enter START_BIT, and drive tx=0 and de=1; tx falls 2 cycles after the accepting edge.
REQ-019 SHALL go START_BIT -> DATA(0) -> ... -> DATA(7) -> STOP_BIT, with each transition on the bit-counter terminal count.
REQ-020 SHALL pulse tx_done for one cycle at the end of STOP_BIT, then go to START_BIT with no idle gap if holding is full, else to DE_HOLD.
REQ-021 SHALL hold tx=1 and de=1 in DE_HOLD for de_hold_bits*clk_per_baud cycles, then enter IDLE with de=0; with de_hold_bits=0, STOP_BIT SHALL go directly to IDLE.
REQ-022 SHALL allow an accept while a frame is shifting; data_valid with ready low SHALL be ignored, and the byte stays the caller's responsibility.
REQ-023 SHALL register tx and de with no combinational path from inputs.
REQ-024 SHALL NOT let a change of data after acceptance affect the frame.

Reset
REQ-025 SHALL, on reset, set tx=1, de=0, ready=1, busy=0, tx_done=0, state IDLE, counter 0, and clear holding, including mid-frame; the partial frame is abandoned.
REQ-026 SHALL ignore data_valid on a cycle where reset is asserted.

Structure
REQ-027 SHALL place state encodings (4-bit localparams) and the clk_per_baud calculation in shared include uart_defs, common with the receiver.
REQ-028 SHALL use one sub-module, uart_baud_counter: clear/enable, bit-period terminal-count pulse.
REQ-029 SHALL fail elaboration if clk_per_baud < 2 or > 65535.

Verification
REQ-030 SHALL test: accept 0x55 at defaults -> tx low 2 cycles later; line 0,1,0,1,0,1,0,1,0,1, each 426 cycles; tx_done once at cycle 4260 after start; de drops 426 cycles later.
REQ-031 SHALL test: 0x01 then 0x03 offered during the first frame -> stop bit of 0x01 directly followed by start of 0x03; de continuous for 8520+426 cycles; two tx_done pulses.
REQ-032 SHALL test: three bytes offered back-to-back -> third held off (ready low) until the second leaves holding; order 1,2,3 preserved.
REQ-033 SHALL test: reset asserted in DATA(3) of 0xA7 -> next edge tx=1, de=0, ready=1; no tx_done; a new byte afterward transmits correctly.
REQ-034 SHALL test: de_hold_bits=0, byte 0xFF -> de deasserts on the edge after the stop bit ends.
REQ-035 SHALL test: a data change one cycle after acceptance -> the originally accepted byte is transmitted.

Source files
------------

// File: rtl/uart_defs_pkg.sv
// Shared UART definitions used by both the transmitter and receiver:
// FSM state encodings and bit-period arithmetic.
package uart_defs_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_START_BIT = 4'd1;
    localparam logic [3:0] ST_DATA      = 4'd2;
    localparam logic [3:0] ST_STOP_BIT  = 4'd3;
    localparam logic [3:0] ST_DE_HOLD   = 4'd4;

    localparam int BAUD_CNT_W   = 16;
    localparam int BAUD_CNT_MAX = 65535;

    // Truncating division: the residual rate error is accepted by design.
    function automatic int calc_clk_per_baud(input int clk_freq_mhz, input int baud);
        return (clk_freq_mhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: down-counter that pulses tc on the last cycle of each
// bit period and reloads itself, so back-to-back bits stay exactly aligned.
module uart_baud_counter
    import uart_defs_pkg::*;
#(
    parameter int clk_per_baud = 426
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [BAUD_CNT_W-1:0] RELOAD = BAUD_CNT_W'(clk_per_baud - 1);

    logic [BAUD_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= RELOAD;
        end else if (enable) begin
            count <= (count == '0) ? RELOAD : count - 1'b1;
        end
    end

    assign tc = enable && !clear && (count == '0);

endmodule

// File: rtl/uart_tx_state_machine.sv
// 8N1 UART transmitter with a one-byte holding register and an RS-485
// driver enable that is held for a configurable number of bit periods.
//
// state        | meaning
// ST_IDLE      | line idle, de low, waiting for the holding register to fill
// ST_START_BIT | driving the start bit (0)
// ST_DATA      | driving data bit bit_idx, LSB first
// ST_STOP_BIT  | driving the stop bit (1); chains straight into the next frame
// ST_DE_HOLD   | line idle high with de still asserted for de_hold_bits periods
module uart_tx_state_machine
    import uart_defs_pkg::*;
#(
    parameter int baudrate     = 187_500,
    parameter int clk_freq_MHz = 80,
    parameter int de_hold_bits = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       de,
    output logic       busy,
    output logic       tx_done
);

    localparam int CLK_PER_BAUD = calc_clk_per_baud(clk_freq_MHz, baudrate);
    localparam logic [15:0] HOLD_BITS = 16'(de_hold_bits);
    localparam bit HAS_DE_HOLD = (de_hold_bits > 0);

    if (CLK_PER_BAUD < 2 || CLK_PER_BAUD > BAUD_CNT_MAX) begin : g_bad_clk_per_baud
        $error("uart_tx_state_machine: clk_per_baud %0d outside 2..65535", CLK_PER_BAUD);
    end

    logic [3:0]  state;
    logic [2:0]  bit_idx;
    logic [15:0] hold_left;
    logic [7:0]  holding_byte;
    logic [7:0]  shift_byte;
    logic        holding_full;
    logic        stop_end;
    logic        bit_tc;
    logic        frame_active;
    logic        start_frame;
    logic        line_bit;

    assign frame_active = (state != ST_IDLE);
    assign start_frame  = holding_full && ((state == ST_IDLE) || (state == ST_DE_HOLD));
    assign ready        = !holding_full;
    assign busy         = frame_active || holding_full || de;

    uart_baud_counter #(
        .clk_per_baud(CLK_PER_BAUD)
    ) u_baud_counter (
        .clk   (clk),
        .reset (reset),
        .clear (start_frame),
        .enable(frame_active),
        .tc    (bit_tc)
    );

    always_comb begin
        line_bit = 1'b1;
        case (state)
            ST_START_BIT: line_bit = 1'b0;
            ST_DATA:      line_bit = shift_byte[bit_idx];
            default:      line_bit = 1'b1;
        endcase
    end

    // Outputs are registered from the state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            bit_idx      <= '0;
            hold_left    <= '0;
            holding_byte <= '0;
            shift_byte   <= '0;
            holding_full <= 1'b0;
            stop_end     <= 1'b0;
            tx           <= 1'b1;
            de           <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            stop_end <= 1'b0;
            tx_done  <= stop_end;
            tx       <= line_bit;
            de       <= frame_active;

            if (data_valid && !holding_full) begin
                holding_full <= 1'b1;
                holding_byte <= data;
            end

            case (state)
                ST_IDLE: begin
                    if (start_frame) begin
                        shift_byte   <= holding_byte;
                        holding_full <= 1'b0;
                        state        <= ST_START_BIT;
                    end
                end
                ST_START_BIT: begin
                    if (bit_tc) begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tc) begin
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP_BIT: begin
                    if (bit_tc) begin
                        stop_end <= 1'b1;
                        if (holding_full) begin
                            shift_byte   <= holding_byte;
                            holding_full <= 1'b0;
                            state        <= ST_START_BIT;
                        end else if (HAS_DE_HOLD) begin
                            hold_left <= HOLD_BITS;
                            state     <= ST_DE_HOLD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DE_HOLD: begin
                    if (start_frame) begin
                        shift_byte   <= holding_byte;
                        holding_full <= 1'b0;
                        state        <= ST_START_BIT;
                    end else if (bit_tc) begin
                        if (hold_left <= 16'd1) begin
                            state <= ST_IDLE;
                        end else begin
                            hold_left <= hold_left - 16'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_state_machine.sv
// Bench for uart_tx_state_machine: a frame-timeline reference model predicts
// tx/de/ready/tx_done every cycle, and a line decoder recovers the sent bytes.
module tb_uart_tx_state_machine;

    localparam int P = 426;
    localparam int H = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_valid;
    logic [7:0] data;
    logic       ready, tx, de, busy, tx_done;
    logic       ready0, tx0, de0, busy0, tx_done0;

    uart_tx_state_machine dut (
        .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
        .ready(ready), .tx(tx), .de(de), .busy(busy), .tx_done(tx_done)
    );

    uart_tx_state_machine #(.de_hold_bits(0)) dut0 (
        .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
        .ready(ready0), .tx(tx0), .de(de0), .busy(busy0), .tx_done(tx_done0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        longint     s;
    } frame_t;

    frame_t     frames[$];
    logic [7:0] exp_q[$];
    logic [7:0] dec_q[$];
    longint     cyc = 0;
    longint     prev_ss = 0;
    longint     acc_edge = 0;
    longint     hold_until = 0;
    bit         have_prev = 0;
    bit         last_acc = 0;
    int         checks = 0;
    int         errors = 0;

    int     mm[8];
    longint mm_first[8];
    string  mm_name[8] = '{"tx", "de", "ready", "tx_done", "tx0", "de0", "ready0", "tx_done0"};

    longint t_tx_fall, t_done, t_done0, t_de_fall, t_de0_fall, de_hi_cnt;
    int     n_done, n_de_rise, stop_err;
    logic   p_tx = 1'b1, p_de = 1'b0, p_de0 = 1'b0;
    bit     dec_act = 0;
    longint dec_s = 0;
    logic [7:0] dec_b;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: each accepted byte becomes a frame whose line start is known.
    function automatic bit m_hold_full(input longint k);
        return (k >= acc_edge) && (k < hold_until);
    endfunction

    function automatic logic m_tx(input longint k);
        foreach (frames[i]) begin
            if (k >= frames[i].s && k < frames[i].s + 10 * P) begin
                int bi;
                logic [7:0] bb;
                bi = int'((k - frames[i].s) / P);
                bb = frames[i].b;
                if (bi == 0) return 1'b0;
                if (bi == 9) return 1'b1;
                return bb[bi - 1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic m_de(input longint k, input int h);
        foreach (frames[i])
            if (k >= frames[i].s && k < frames[i].s + (10 + h) * P) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_done(input longint k);
        foreach (frames[i])
            if (k == frames[i].s + 10 * P) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [7:0] d, input longint e);
        last_acc = 0;
        if (r) begin
            for (int i = frames.size() - 1; i >= 0; i--)
                if (frames[i].s + 10 * P > e && exp_q.size() > 0) void'(exp_q.pop_back());
            frames.delete();
            have_prev  = 0;
            hold_until = 0;
            acc_edge   = 0;
        end else if (v && !m_hold_full(e - 1)) begin
            longint ss;
            frame_t f;
            ss = e + 1;
            if (have_prev && prev_ss + 10 * P > ss) ss = prev_ss + 10 * P;
            f.b = d;
            f.s = ss + 1;
            frames.push_back(f);
            exp_q.push_back(d);
            prev_ss    = ss;
            have_prev  = 1;
            acc_edge   = e;
            hold_until = ss;
            last_acc   = 1;
        end
        if (frames.size() > 4) void'(frames.pop_front());
    endtask

    task automatic compare_outputs(input longint k);
        logic obs[8];
        logic ex[8];
        obs = '{tx, de, ready, tx_done, tx0, de0, ready0, tx_done0};
        ex  = '{m_tx(k), m_de(k, H), !m_hold_full(k), m_done(k),
                m_tx(k), m_de(k, 0), !m_hold_full(k), m_done(k)};
        for (int i = 0; i < 8; i++) begin
            if (obs[i] !== ex[i]) begin
                if (mm[i] == 0) mm_first[i] = k;
                mm[i]++;
            end
        end
        if (p_tx && !tx && t_tx_fall < 0) t_tx_fall = k;
        if (tx_done) begin
            n_done++;
            if (t_done < 0) t_done = k;
        end
        if (tx_done0 && t_done0 < 0) t_done0 = k;
        if (p_de && !de) t_de_fall = k;
        if (!p_de && de) n_de_rise++;
        if (p_de0 && !de0) t_de0_fall = k;
        if (de) de_hi_cnt++;
        // Behavioural receiver sampling mid-bit.
        if (!dec_act) begin
            if (p_tx && !tx) begin
                dec_act = 1;
                dec_s   = k;
            end
        end else begin
            for (int i = 1; i <= 8; i++)
                if (k - dec_s == i * P + P / 2) dec_b[i - 1] = tx;
            if (k - dec_s == 9 * P + P / 2) begin
                if (tx !== 1'b1) stop_err++;
                dec_q.push_back(dec_b);
                dec_act = 0;
            end
        end
        p_tx  = tx;
        p_de  = de;
        p_de0 = de0;
    endtask

    task automatic tick(input logic r, input logic v, input logic [7:0] d);
        reset      = r;
        data_valid = v;
        data       = d;
        model_edge(r, v, d, cyc + 1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (r) dec_act = 0;
        compare_outputs(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic send(input logic [7:0] b, output longint a);
        int n = 0;
        last_acc = 0;
        while (!last_acc && n < 20000) begin
            tick(1'b0, 1'b1, b);
            n++;
        end
        check_val("send_accepted", longint'(last_acc), 1);
        a = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 30000 && ((have_prev && cyc < prev_ss + 1 + 11 * P + 3) || m_hold_full(cyc))) begin
            tick(1'b0, 1'b0, 8'($urandom));
            n++;
        end
        check_val("wait_idle_in_budget", longint'(n < 30000), 1);
    endtask

    task automatic clr_trk();
        t_tx_fall  = -1;
        t_done     = -1;
        t_done0    = -1;
        t_de_fall  = -1;
        t_de0_fall = -1;
        de_hi_cnt  = 0;
        n_done     = 0;
        n_de_rise  = 0;
    endtask

    task automatic flush(input string tag);
        int n;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("%s_%s_mismatches(first@%0d)", tag, mm_name[i], mm_first[i]), mm[i], 0);
            mm[i] = 0;
        end
        check_val({tag, "_stop_bit_errors"}, stop_err, 0);
        check_val({tag, "_byte_count"}, dec_q.size(), exp_q.size());
        n = (dec_q.size() < exp_q.size()) ? dec_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_val($sformatf("%s_byte%0d", tag, i), dec_q[i], exp_q[i]);
        stop_err = 0;
        dec_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint a, a1, a2, r_edge;
        for (int i = 0; i < 8; i++) begin
            mm[i] = 0;
            mm_first[i] = 0;
        end
        stop_err = 0;
        clr_trk();

        // Reset, with data_valid held high to show it is ignored.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 8'hAA);
        check_val("rst_tx", tx, 1);
        check_val("rst_de", de, 0);
        check_val("rst_ready", ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_tx_done", tx_done, 0);
        tick(1'b0, 1'b0, 8'h00);
        check_val("post_rst_ready", ready, 1);

        // Single byte 0x55 at default parameters.
        clr_trk();
        send(8'h55, a);
        check_val("s2_busy_after_accept", busy, 1);
        wait_idle();
        check_val("s2_tx_fall_latency", t_tx_fall - a, 2);
        check_val("s2_done_count", n_done, 1);
        check_val("s2_done_after_start", t_done - t_tx_fall, 10 * P);
        check_val("s2_de_drop_after_done", t_de_fall - t_done, H * P);
        check_val("s2_de0_drop_vs_done0", t_de0_fall - t_done0, 0);
        check_val("s2_busy_idle", busy, 0);
        check_val("s2_busy0_idle", busy0, 0);
        flush("s2");

        // Second byte offered mid-frame chains with no idle gap.
        clr_trk();
        send(8'h01, a1);
        idle(1000);
        send(8'h03, a2);
        wait_idle();
        check_val("s3_done_count", n_done, 2);
        check_val("s3_de_high_cycles", de_hi_cnt, 20 * P + H * P);
        check_val("s3_de_rises", n_de_rise, 1);
        check_val("s3_de_span", t_de_fall - t_tx_fall, 20 * P + H * P);
        flush("s3");

        // Three bytes back-to-back; third must wait for holding to empty.
        clr_trk();
        send(8'h01, a);
        send(8'h02, a);
        send(8'h03, a);
        wait_idle();
        check_val("s4_done_count", n_done, 3);
        flush("s4");

        // Reset during DATA(3) of 0xA7 with 0x99 waiting in holding.
        clr_trk();
        send(8'hA7, a);
        r_edge = a + 2 + 4 * P + 100;
        while (cyc < a + 1000) tick(1'b0, 1'b0, 8'($urandom));
        send(8'h99, a1);
        check_val("s5_ready_before_reset", ready, 0);
        while (cyc + 1 < r_edge) tick(1'b0, 1'b0, 8'($urandom));
        tick(1'b1, 1'b0, 8'h00);
        check_val("s5_rst_tx", tx, 1);
        check_val("s5_rst_de", de, 0);
        check_val("s5_rst_ready", ready, 1);
        check_val("s5_rst_busy", busy, 0);
        idle(20);
        check_val("s5_no_tx_done", n_done, 0);
        send(8'h3C, a);
        wait_idle();
        check_val("s5_done_after_recover", n_done, 1);
        flush("s5");

        // No DE hold: de0 drops together with tx_done0.
        clr_trk();
        send(8'hFF, a);
        wait_idle();
        check_val("s6_de0_drop_vs_done0", t_de0_fall - t_done0, 0);
        check_val("s6_de0_drop_after_start", t_de0_fall - t_tx_fall, 10 * P);
        flush("s6");

        // Data changes after acceptance; second offer while not ready is ignored.
        clr_trk();
        tick(1'b0, 1'b1, 8'h5A);
        check_val("s7_accepted", longint'(last_acc), 1);
        tick(1'b0, 1'b1, 8'hA5);
        tick(1'b0, 1'b0, 8'hA5);
        wait_idle();
        if (dec_q.size() > 0) check_val("s7_sent_byte", dec_q[0], 8'h5A);
        check_val("s7_done_count", n_done, 1);
        flush("s7");

        // Random bytes with random gaps, some landing mid-frame.
        clr_trk();
        for (int i = 0; i < 4; i++) begin
            idle(int'($urandom_range(0, 2000)));
            send(8'($urandom), a);
        end
        wait_idle();
        check_val("s8_done_count", n_done, 4);
        flush("s8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
